// File: rtl/cascade_down_timer_pkg.sv
// cascade_down_timer_pkg: state encoding, digit width and per-digit modulus extraction.
package cascade_down_timer_pkg;
   localparam int DIGIT_W = 4;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3} state_t;
   function automatic logic [DIGIT_W-1:0] digit_mod(input logic [63:0] moduli, input int i);
      return moduli[i*DIGIT_W +: DIGIT_W];
   endfunction
endpackage

// File: rtl/cascade_down_timer_if.sv
// cascade_down_timer_if: control and count bus between the timer and its driver.
interface cascade_down_timer_if #(parameter int NUM_DIGITS = 4);
   logic                    CE, LOAD, START, PAUSE;
   logic [4*NUM_DIGITS-1:0] LOAD_VAL, Q;
   logic                    BUSY, PAUSED, DONE_P, EXPIRED;
   modport master(output CE, LOAD, LOAD_VAL, START, PAUSE, input Q, BUSY, PAUSED, DONE_P, EXPIRED);
   modport slave(input CE, LOAD, LOAD_VAL, START, PAUSE, output Q, BUSY, PAUSED, DONE_P, EXPIRED);
endinterface

// File: rtl/cascade_digit.sv
// cascade_digit: one modulo-MOD down-counting digit with clamped load and wrap on step.
module cascade_digit #(parameter logic [3:0] MOD = 4'd10) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       LD,
   input  logic [3:0] LD_VAL,
   input  logic       STEP,
   output logic [3:0] Q,
   output logic       ZERO
);
   always_ff @(posedge CLK or posedge CLR)
      if (CLR) Q <= '0;
      else if (LD) Q <= (LD_VAL >= MOD) ? MOD - 4'd1 : LD_VAL;
      else if (STEP) Q <= (Q == '0) ? MOD - 4'd1 : Q - 4'd1;
   assign ZERO = (Q == '0);
endmodule

// File: rtl/cascade_down_timer.sv
// cascade_down_timer: cascaded multi-digit countdown with load/reload, start/pause FSM and done pulse.
// Define CASCADE_DOWN_TIMER_AUTO_RELOAD_EN to restart from the reload value at the terminal tick.
module cascade_down_timer
   import cascade_down_timer_pkg::*;
#(
   parameter int                      NUM_DIGITS = 4,
   parameter logic [4*NUM_DIGITS-1:0] MODULI     = 16'h6A6A
) (
   input logic CLK,
   input logic CLR,
   cascade_down_timer_if.slave bus
);
   localparam int W = DIGIT_W * NUM_DIGITS;
`ifdef CASCADE_DOWN_TIMER_AUTO_RELOAD_EN
   localparam bit AUTO_RL = 1'b1;
`else
   localparam bit AUTO_RL = 1'b0;
`endif
   state_t                state;
   logic [W-1:0]          q, rld, ld_val;
   logic [NUM_DIGITS-1:0] zero, brw;
   logic                  dec, term, reload, ld, done_p;
   assign dec    = (state == RUN) && !bus.LOAD && !bus.PAUSE && bus.CE;
   assign term   = dec && (q[DIGIT_W-1:0] == 4'd1) && (&zero[NUM_DIGITS-1:1]);
   assign reload = AUTO_RL && term && (rld != '0);
   assign ld     = bus.LOAD || reload;
   assign ld_val = bus.LOAD ? bus.LOAD_VAL : rld;
   assign brw[0] = 1'b1;
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
      if (i > 0) begin : g_brw
         assign brw[i] = brw[i-1] & zero[i-1];
      end
      cascade_digit #(.MOD(digit_mod(64'(MODULI), i))) u_dig (
         .CLK    (CLK),
         .CLR    (CLR),
         .LD     (ld),
         .LD_VAL (ld_val[i*DIGIT_W +: DIGIT_W]),
         .STEP   (dec & brw[i]),
         .Q      (q[i*DIGIT_W +: DIGIT_W]),
         .ZERO   (zero[i])
      );
   end
   // Raw load value is kept; the digits clamp it again whenever it is reloaded.
   always_ff @(posedge CLK or posedge CLR)
      if (CLR) begin
         state  <= IDLE;
         rld    <= '0;
         done_p <= 1'b0;
      end else begin
         done_p <= term && !done_p;
         if (bus.LOAD) begin
            state <= IDLE;
            rld   <= bus.LOAD_VAL;
         end
         else if (state == IDLE) state <= (!bus.PAUSE && bus.START && q != '0) ? RUN : IDLE;
         else if (state == RUN) state <= bus.PAUSE ? HOLD : (term && !reload) ? DONE : RUN;
         else if (state == HOLD) state <= (!bus.PAUSE && bus.START) ? RUN : HOLD;
      end
   assign bus.Q       = q;
   assign bus.BUSY    = (state == RUN);
   assign bus.PAUSED  = (state == HOLD);
   assign bus.EXPIRED = (state == DONE);
   assign bus.DONE_P  = done_p;
endmodule

// File: tb/tb_cascade_down_timer.sv
// tb_cascade_down_timer: directed vector table plus hand sequences for the MM:SS countdown timer.
module tb_cascade_down_timer;
   typedef struct {
      logic ce, load, start, pause;
      logic [15:0] lv, q;
      logic busy, paused, dp, exp;
   } vec_t;
   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;
   cascade_down_timer_if #(.NUM_DIGITS(4)) bus();
   cascade_down_timer #(.NUM_DIGITS(4), .MODULI(16'h6A6A)) dut (.CLK(clk), .CLR(clr), .bus(bus));
   int   nvec = 0;
   int   nerr = 0;
   vec_t tbl[$];
   function automatic vec_t v(logic ce, logic load, logic start, logic pause, logic [15:0] lv,
                              logic [15:0] q, logic busy, logic paused, logic dp, logic exp);
      vec_t r;
      r.ce = ce; r.load = load; r.start = start; r.pause = pause; r.lv = lv;
      r.q = q; r.busy = busy; r.paused = paused; r.dp = dp; r.exp = exp;
      return r;
   endfunction
   function automatic logic [15:0] mmss(int s);
      int m, ss;
      m  = s / 60;
      ss = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction
   task automatic check(string name, logic [15:0] q, logic busy, logic paused, logic dp, logic exp);
      nvec++;
      if ({bus.Q, bus.BUSY, bus.PAUSED, bus.DONE_P, bus.EXPIRED} !== {q, busy, paused, dp, exp}) begin
         nerr++;
         $display("FAIL %s: got Q=%h busy=%b paused=%b done_p=%b expired=%b, want Q=%h busy=%b paused=%b done_p=%b expired=%b",
                  name, bus.Q, bus.BUSY, bus.PAUSED, bus.DONE_P, bus.EXPIRED, q, busy, paused, dp, exp);
      end
   endtask
   task automatic drive(logic ce, logic load, logic start, logic pause, logic [15:0] lv);
      @(negedge clk);
      bus.CE = ce; bus.LOAD = load; bus.START = start; bus.PAUSE = pause; bus.LOAD_VAL = lv;
   endtask
   task automatic apply(vec_t x, string name);
      drive(x.ce, x.load, x.start, x.pause, x.lv);
      @(posedge clk);
      #1;
      check(name, x.q, x.busy, x.paused, x.dp, x.exp);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want completion");
      $fatal(1);
   end
   initial begin
      bus.CE = 0; bus.LOAD = 0; bus.START = 0; bus.PAUSE = 0; bus.LOAD_VAL = '0;
      #12;
      check("reset", 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      clr = 1'b0;
`ifdef CASCADE_DOWN_TIMER_AUTO_RELOAD_EN
      tbl.push_back(v(0, 1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h0002, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 1, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0, 0));
`else
      tbl.push_back(v(0, 1, 0, 0, 16'h0003, 16'h0003, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h0003, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0001, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 1));
      tbl.push_back(v(1, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 1));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1));
`endif
      tbl.push_back(v(0, 1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h0100, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0059, 1, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h0010, 16'h0010, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h0010, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0009, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0008, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0007, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 1, 16'h0000, 16'h0007, 0, 1, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0007, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 1, 16'h0000, 16'h0007, 0, 1, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h0007, 1, 0, 0, 0));
      tbl.push_back(v(1, 0, 1, 0, 16'h0000, 16'h0006, 1, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h00FF, 16'h0059, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'hFFFF, 16'h5959, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 1, 0, 16'h0012, 16'h0012, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0012, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 1, 0, 16'h0000, 16'h0012, 1, 0, 0, 0));
      tbl.push_back(v(1, 1, 0, 0, 16'h0034, 16'h0034, 0, 0, 0, 0));
      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
`ifndef CASCADE_DOWN_TIMER_AUTO_RELOAD_EN
      drive(0, 1, 0, 0, 16'h0100);
      drive(0, 0, 1, 0, 16'h0000);
      for (int k = 1; k <= 60; k++) begin
         drive(1, 0, 0, 0, 16'h0000);
         @(posedge clk);
         #1;
         check($sformatf("tick%0d", k), mmss(60 - k), k < 60, 0, k == 60, k == 60);
      end
`endif
      drive(0, 1, 0, 0, 16'h0043);
      drive(0, 0, 1, 0, 16'h0000);
      drive(1, 0, 0, 0, 16'h0000);
      @(posedge clk);
      #1;
      check("pre_clr", 16'h0042, 1, 0, 0, 0);
      @(negedge clk);
      #2;
      clr = 1'b1;
      #1;
      check("async_clr", 16'h0000, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      check("clr_held", 16'h0000, 0, 0, 0, 0);
      @(negedge clk);
      clr = 1'b0;
      bus.CE = 0; bus.LOAD = 0; bus.START = 0; bus.PAUSE = 0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
